password_entry: RTL and testbench

Keypad digit-entry buffer that sits directly upstream of the password comparator. It collects up to four decimal digits from single-cycle key events and supports backspace, clear and enter. It presents the digits on pass_buf0..pass_buf3 and pulses entry_done when a complete 4-digit code is submitted. The buffers are then frozen for a hold window, so the downstream match result is stable while it is sampled.

---
 rtl/password_entry.sv | 157 +++++++++++++++
 tb/tb_password_entry.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/password_entry.sv
// Keypad digit-entry buffer: collects up to four decimal digits with backspace/clear/enter,
// then freezes the submitted code for a hold window while the comparator samples it.
module password_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter logic [3:0]  EMPTY_DIGIT    = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] pass_buf0,
  output logic [3:0] pass_buf1,
  output logic [3:0] pass_buf2,
  output logic [3:0] pass_buf3,
  output logic [2:0] digit_count,
  output logic       entry_done,
  output logic       entry_err,
  output logic       timeout,
  output logic       busy
);

  localparam int TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  // Timers count down to zero; loading N-1 gives exactly N cycles until expiry.
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [3:0]        buf_q [4];
  logic [3:0]        buf_d [4];
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        cnt_m1;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              tout_q, tout_d;
  logic              busy_q, busy_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic key_digit, key_bksp, key_enter, key_clear;

  assign key_digit = key_valid && (key_code <= 4'h9);
  assign key_bksp  = key_valid && (key_code == 4'hA);
  assign key_enter = key_valid && (key_code == 4'hB);
  assign key_clear = key_valid && (key_code == 4'hC);
  assign cnt_m1    = cnt_q - 3'd1;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tout_d  = 1'b0;
    busy_d  = busy_q;
    tmr_d   = tmr_q;
    hold_d  = hold_q;

    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (key_digit) begin
          if (cnt_q < 3'd4) begin
            buf_d[cnt_q[1:0]] = key_code;
            cnt_d             = cnt_q + 3'd1;
          end
          state_d = S_ENTRY;
          tmr_d   = TMR_LOAD;
        end else if (key_bksp) begin
          if (cnt_q != 3'd0) begin
            buf_d[cnt_m1[1:0]] = EMPTY_DIGIT;
            cnt_d              = cnt_m1;
            tmr_d              = TMR_LOAD;
            if (cnt_m1 == 3'd0) begin
              state_d = S_IDLE;
              tmr_d   = '0;
            end
          end
        end else if (key_enter) begin
          if (cnt_q == 3'd4) begin
            done_d  = 1'b1;
            busy_d  = 1'b1;
            hold_d  = HOLD_LOAD;
            tmr_d   = '0;
            state_d = S_HOLD;
          end else begin
            err_d = 1'b1;
            // A short enter counts as activity only once a partial code exists.
            if (state_q == S_ENTRY) tmr_d = TMR_LOAD;
          end
        end else if (key_clear) begin
          for (int i = 0; i < 4; i++) buf_d[i] = EMPTY_DIGIT;
          cnt_d   = 3'd0;
          tmr_d   = '0;
          state_d = S_IDLE;
        end else if (state_q == S_ENTRY) begin
          if (tmr_q == '0) begin
            for (int i = 0; i < 4; i++) buf_d[i] = EMPTY_DIGIT;
            cnt_d   = 3'd0;
            tout_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          for (int i = 0; i < 4; i++) buf_d[i] = EMPTY_DIGIT;
          cnt_d   = 3'd0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 4; i++) buf_q[i] <= EMPTY_DIGIT;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
      busy_q  <= 1'b0;
      tmr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
      busy_q  <= busy_d;
      tmr_q   <= tmr_d;
      hold_q  <= hold_d;
    end
  end

  assign pass_buf0   = buf_q[0];
  assign pass_buf1   = buf_q[1];
  assign pass_buf2   = buf_q[2];
  assign pass_buf3   = buf_q[3];
  assign digit_count = cnt_q;
  assign entry_done  = done_q;
  assign entry_err   = err_q;
  assign timeout     = tout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_password_entry.sv
// Directed bench for password_entry: keys driven at the falling edge, outputs sampled there too.
module tb_password_entry;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] pass_buf0, pass_buf1, pass_buf2, pass_buf3;
  logic [2:0] digit_count;
  logic       entry_done, entry_err, timeout, busy;

  int checks   = 0;
  int failures = 0;

  password_entry #(
    .TIMEOUT_CYCLES(1000),
    .HOLD_CYCLES(16),
    .EMPTY_DIGIT(4'hF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .key_code(key_code),
    .pass_buf0(pass_buf0),
    .pass_buf1(pass_buf1),
    .pass_buf2(pass_buf2),
    .pass_buf3(pass_buf3),
    .digit_count(digit_count),
    .entry_done(entry_done),
    .entry_err(entry_err),
    .timeout(timeout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_buf(input string tag, input logic [15:0] exp);
    chk(tag, 32'({pass_buf0, pass_buf1, pass_buf2, pass_buf3}), 32'(exp));
  endtask

  task automatic chk_cnt(input string tag, input logic [2:0] exp);
    chk(tag, 32'(digit_count), 32'(exp));
  endtask

  // Order: {entry_done, entry_err, timeout}
  task automatic chk_pulse(input string tag, input logic [2:0] exp);
    chk(tag, 32'({entry_done, entry_err, timeout}), 32'(exp));
  endtask

  task automatic chk_busy(input string tag, input logic exp);
    chk(tag, 32'(busy), 32'(exp));
  endtask

  // Called at a falling edge; returns at the next falling edge, after the key was processed.
  task automatic key(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n_busy;
    int n_done;

    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    idle(2);
    chk_buf("reset_bufs", 16'hFFFF);
    chk_cnt("reset_cnt", 3'd0);
    chk_pulse("reset_pulses", 3'b000);
    chk_busy("reset_busy", 1'b0);
    rst = 1'b0;
    idle(1);

    // 1: full code and hold window
    key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    chk_buf("t1_bufs", 16'h1234);
    chk_cnt("t1_cnt", 3'd4);
    chk_pulse("t1_no_pulse_before_enter", 3'b000);
    key(4'hB);
    chk_pulse("t1_done", 3'b100);
    chk_busy("t1_busy", 1'b1);
    chk_buf("t1_frozen", 16'h1234);
    n_busy = 0;
    n_done = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      n_busy++;
      n_done += int'(entry_done);
      @(negedge clk);
    end
    chk("t1_busy_cycles", 32'(n_busy), 32'd16);
    chk("t1_done_cycles", 32'(n_done), 32'd1);
    chk_buf("t1_cleared", 16'hFFFF);
    chk_cnt("t1_cleared_cnt", 3'd0);

    // 2: backspace mid-entry, then backspace in IDLE
    key(4'h5); key(4'h6); key(4'hA);
    chk_cnt("t2_bksp_cnt", 3'd1);
    chk_buf("t2_bksp_bufs", 16'h5FFF);
    key(4'h7); key(4'h8); key(4'h9); key(4'hB);
    chk_pulse("t2_done", 3'b100);
    chk_buf("t2_bufs", 16'h5789);
    idle(16);
    chk_busy("t2_hold_end", 1'b0);
    key(4'hA);
    chk_cnt("t2_idle_bksp_cnt", 3'd0);
    chk_buf("t2_idle_bksp_bufs", 16'hFFFF);
    chk_pulse("t2_idle_bksp_pulse", 3'b000);

    // 3: short enter, then complete it
    key(4'h1); key(4'h2); key(4'hB);
    chk_pulse("t3_err", 3'b010);
    chk_buf("t3_err_bufs", 16'h12FF);
    chk_cnt("t3_err_cnt", 3'd2);
    idle(1);
    chk_pulse("t3_err_once", 3'b000);
    key(4'h3); key(4'h4); key(4'hB);
    chk_pulse("t3_done", 3'b100);
    chk_buf("t3_bufs", 16'h1234);
    idle(16);
    chk_busy("t3_hold_end", 1'b0);

    // 4: fifth digit ignored, then clear
    key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'h5);
    chk_buf("t4_full_bufs", 16'h1234);
    chk_cnt("t4_full_cnt", 3'd4);
    key(4'hC);
    chk_buf("t4_clear_bufs", 16'hFFFF);
    chk_cnt("t4_clear_cnt", 3'd0);
    chk_pulse("t4_clear_pulse", 3'b000);

    // 5: inactivity timeout, then a key landing in the expiry cycle
    key(4'h9);
    idle(999);
    chk_pulse("t5_before_expiry", 3'b000);
    chk_cnt("t5_before_expiry_cnt", 3'd1);
    idle(1);
    chk_pulse("t5_timeout", 3'b001);
    chk_cnt("t5_timeout_cnt", 3'd0);
    chk_buf("t5_timeout_bufs", 16'hFFFF);
    idle(1);
    chk_pulse("t5_timeout_once", 3'b000);
    key(4'h9);
    idle(999);
    key(4'h2);
    chk_pulse("t5_key_wins", 3'b000);
    chk_cnt("t5_key_wins_cnt", 3'd2);
    chk_buf("t5_key_wins_bufs", 16'h92FF);
    idle(1);
    chk_pulse("t5_reloaded", 3'b000);
    key(4'hC);

    // 6: key during HOLD ignored, async reset mid-HOLD
    key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'hB);
    key(4'h0);
    chk_cnt("t6_hold_key_cnt", 3'd4);
    chk_buf("t6_hold_key_bufs", 16'h1234);
    chk_busy("t6_hold_busy", 1'b1);
    idle(3);
    #1 rst = 1'b1;
    #1;
    chk_busy("t6_async_busy", 1'b0);
    chk_cnt("t6_async_cnt", 3'd0);
    chk_buf("t6_async_bufs", 16'hFFFF);
    chk_pulse("t6_async_pulse", 3'b000);
    idle(1);
    rst = 1'b0;
    idle(2);
    chk_busy("t6_after_rst_busy", 1'b0);
    chk_cnt("t6_after_rst_cnt", 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
